// File: rtl/seq_detect_mealy.sv
// Mealy serial-pattern detector with a runtime-loadable PAT_W-bit pattern,
// optional overlapping detection and a saturating match counter.
module seq_detect_mealy #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

    typedef enum logic {
        StFill,
        StArmed
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [FILL_W-1:0]  r_fill;
    logic [FILL_W-1:0]  w_fill_d;
    logic [PAT_W-2:0]   r_hist;
    logic [PAT_W-2:0]   w_hist_d;
    logic [PAT_W-1:0]   r_pattern;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_d;
    logic [PAT_W-1:0]   w_window;

    assign w_window = {r_hist, in_bit};

    // Reset and cfg_load override everything below inside the state register.
    always_comb begin
        w_state_d = r_state;
        w_fill_d  = r_fill;
        w_hist_d  = r_hist;
        w_count_d = r_count;
        match     = 1'b0;

        if (!reset && !cfg_load && in_valid) begin
            case (r_state)
                StFill: begin
                    w_hist_d = w_window[PAT_W-2:0];
                    w_fill_d = r_fill + FILL_W'(1);
                    if (r_fill == FILL_LAST) begin
                        w_state_d = StArmed;
                    end
                end
                StArmed: begin
                    w_hist_d = w_window[PAT_W-2:0];
                    if (w_window == r_pattern) begin
                        match = 1'b1;
                        if (!r_overlap) begin
                            w_hist_d  = '0;
                            w_fill_d  = '0;
                            w_state_d = StFill;
                        end
                    end
                end
                default: begin
                    w_state_d = StFill;
                end
            endcase
        end

        if (match && (r_count != {CNT_W{1'b1}})) begin
            w_count_d = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StFill;
            r_fill    <= '0;
            r_hist    <= '0;
            r_pattern <= '0;
            r_overlap <= 1'b1;
            r_count   <= '0;
        end else if (cfg_load) begin
            r_state   <= StFill;
            r_fill    <= '0;
            r_hist    <= '0;
            r_pattern <= cfg_pattern;
            r_overlap <= cfg_overlap;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_fill    <= w_fill_d;
            r_hist    <= w_hist_d;
            r_count   <= w_count_d;
        end
    end

    assign armed       = (r_state == StArmed);
    assign match_count = r_count;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// Scoreboard bench for seq_detect_mealy: directed rows push expectations,
// a negedge monitor pops and compares both an 8-bit and a 2-bit counter instance.
module tb_seq_detect_mealy;

    bit         clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       cfg_overlap = 1'b1;

    logic       match_a, armed_a;
    logic [7:0] count_a;
    logic       match_b, armed_b;
    logic [1:0] count_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic       match;
        logic       armed;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    seq_detect_mealy #(.PAT_W(4), .CNT_W(8)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .match       (match_a),
        .armed       (armed_a),
        .match_count (count_a)
    );

    seq_detect_mealy #(.PAT_W(4), .CNT_W(2)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_overlap (cfg_overlap),
        .match       (match_b),
        .armed       (armed_b),
        .match_count (count_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    initial begin
        exp_t       e;
        logic [7:0] sat;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                sat = (e.cnt > 8'd3) ? 8'd3 : e.cnt;
                check({e.name, " match"},   {7'd0, match_a}, {7'd0, e.match});
                check({e.name, " armed"},   {7'd0, armed_a}, {7'd0, e.armed});
                check({e.name, " count"},   count_a,         e.cnt);
                check({e.name, " match2"},  {7'd0, match_b}, {7'd0, e.match});
                check({e.name, " armed2"},  {7'd0, armed_b}, {7'd0, e.armed});
                check({e.name, " count2"},  {6'd0, count_b}, sat);
            end
        end
    end

    task automatic step(input string name, input logic rst, input logic ld,
                        input logic [3:0] pat, input logic ovl, input logic v,
                        input logic b, input logic em, input logic ea,
                        input logic [7:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_overlap = ovl;
        in_valid    = v;
        in_bit      = b;
        e.name  = name;
        e.match = em;
        e.armed = ea;
        e.cnt   = ec;
        sb_q.push_back(e);
    endtask

    // Plain data bit, no reset/load.
    task automatic bitv(input string name, input logic v, input logic b,
                        input logic em, input logic ea, input logic [7:0] ec);
        step(name, 1'b0, 1'b0, 4'b0000, 1'b0, v, b, em, ea, ec);
    endtask

    initial begin
        // Reset held with valid toggling bits: nothing may match.
        for (int i = 0; i < 4; i++) begin
            step("rst", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'(i % 2), 1'b0, 1'b0, 8'd0);
        end
        bitv("rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // 1011 overlapping: matches on bits 4 and 7.
        step("ld_ov", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("ov_b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("ov_b2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("ov_b3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("ov_b4", 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        bitv("ov_b5", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        bitv("ov_b6", 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        bitv("ov_b7", 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
        bitv("ov_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);

        // Same stream non-overlapping: single match, history cleared.
        step("ld_no", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        bitv("no_b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("no_b2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("no_b3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("no_b4", 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        bitv("no_b5", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        bitv("no_b6", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        bitv("no_b7", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        bitv("no_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // Gaps in in_valid do not break the sequence.
        step("ld_gap", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        bitv("gap_b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("gap_b2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("gap_i1", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("gap_i2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("gap_i3", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("gap_b3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("gap_b4", 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        bitv("gap_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // cfg_load mid-sequence discards history and the concurrent bit.
        step("ld_mid", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        bitv("mid_b1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("mid_b2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("mid_b3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        step("mid_ld", 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
        bitv("mid_c1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("mid_c2", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        bitv("mid_c3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        bitv("mid_c4", 1'b1, 1'b1, 1'b1, 1'b1, 8'd0);
        bitv("mid_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

        // 1111 overlapping, ten ones: seven matches; 2-bit counter sticks at 3.
        step("ld_sat", 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        for (int i = 1; i <= 10; i++) begin
            bitv($sformatf("sat_b%0d", i), 1'b1, 1'b1, 1'(i >= 4), 1'(i >= 4),
                 (i >= 5) ? 8'(i - 4) : 8'd0);
        end
        bitv("sat_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd7);

        // Reset while armed and a matching bit is presented.
        step("rst_arm", 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd7);
        bitv("rst_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            fails++;
            tests++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised Mealy serial-pattern detector, successor to the team's fixed 3-state Mealy FSM. Matches a runtime-loadable PAT_W-bit pattern on a qualified serial bit stream. Supports overlapping and non-overlapping detection and counts matches. Sits between a serialiser/bit-sampler front end and downstream event or interrupt logic.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the saturating match counter.

- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high.
- in_valid  input  1  qualifies in_bit; bits with in_valid=0 are ignored.
- in_bit  input  1  serial data bit.
- cfg_load  input  1  loads cfg_pattern and cfg_overlap; restarts detection.
- cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the oldest (first-received) bit, bit 0 the newest.
- cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match.
- match  output  1  Mealy output, combinational: high in the cycle whose valid bit completes the pattern.
- armed  output  1  registered; high when PAT_W-1 valid bits are held in history.
- match_count  output  CNT_W  registered saturating count of matches since reset/cfg_load.

## Operation
- Registers: pattern_q (PAT_W), overlap_q, hist (PAT_W-1 bits), fill (count 0..PAT_W-1), match_count.
- Reset values: pattern_q=0, overlap_q=1, hist=0, fill=0, armed=0, match_count=0; match forced 0 while reset is high.
- FSM: two states derived from fill.
  - FILL (fill < PAT_W-1): each valid bit shifts into hist ({hist[PAT_W-3:0], in_bit}); fill increments. match=0.
  - ARMED (fill == PAT_W-1): match = in_valid & ({hist, in_bit} == pattern_q).
    - Valid bit, no match: shift into hist, stay ARMED.
    - Valid bit, match, overlap_q=1: shift into hist, stay ARMED.
    - Valid bit, match, overlap_q=0: hist cleared to 0, fill=0, go to FILL.
- in_valid=0: no state change; match=0.
- match_count increments by 1 on each match; saturates at 2^CNT_W-1 and never wraps.
- cfg_load=1: pattern_q<=cfg_pattern, overlap_q<=cfg_overlap, hist<=0, fill<=0, match_count<=0. match forced 0 in that cycle; any concurrent in_bit is discarded.
- Priority: reset > cfg_load > in_valid.
- Reset or cfg_load mid-sequence discards the partial history; a pattern straddling the event is never matched.

## Timing
- match: zero latency; asserted combinationally from in_valid/in_bit in the same cycle as the completing bit. It is not registered.
- match_count: updates on the rising edge that ends the match cycle; visible 1 cycle after match.
- armed: rises on the edge that stores the (PAT_W-1)th valid bit. It falls on the edge following a non-overlap match, cfg_load or reset.
- First possible match: the PAT_W-th valid bit after reset or cfg_load.
- Back-to-back in_valid every cycle is supported. Gaps in in_valid do not break a sequence.

## Test plan
- Reset with in_valid=1 and in_bit toggling -> match=0 throughout; after release armed=0 and match_count=0.
- cfg_load pattern=4'b1011, overlap=1; stream 1,0,1,1,0,1,1 (valid every cycle) -> match high on bits 4 and 7; match_count=2 one cycle after bit 7.
- Same stream with overlap=0 -> match only on bit 4; armed drops after bit 4; match_count=1.
- pattern=4'b1011, stream 1,0,(in_valid=0 for 3 cycles),1,1 -> match on the final bit; idle cycles cause no change.
- CNT_W=2, pattern=4'b1111, overlap=1, 10 consecutive 1s -> 7 matches; match_count stays at 3 after the 3rd match, no wrap.
- After 1,0,1 of 4'b1011, assert cfg_load with in_valid=1, in_bit=1 -> match=0, fill=0. A new full pattern is required before the next match.
